// File: rtl/ext_mem_latency_model.sv
// rtl/ext_mem_latency_model.sv - parametrised external memory with configurable read latency
//
// Serves a cache memory port: request channel, separate write-data channel and an
// unthrottled response channel. Reads are snapshotted into an in-order response
// queue and returned exactly LATENCY cycles after acceptance; writes are byte-masked
// and produce no response.
//
// Ports:
//   clk, reset_n                          clock and asynchronous active-low reset
//   mem_req_valid/ready/rw/addr/tag        request channel (rw: 1 = write)
//   mem_req_data_valid/ready/bits/mask     write-data channel, accepted only after a write request
//   mem_resp_valid/tag/data                one-cycle read response pulse, registered
//   outstanding                            number of reads in flight
module ext_mem_latency_model #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5,
    parameter int RAM_WORDS = 1024,
    parameter int LATENCY   = 4,
    parameter int QDEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mem_req_valid,
    output logic                      mem_req_ready,
    input  logic                      mem_req_rw,
    input  logic [ADDR_BITS-1:0]      mem_req_addr,
    input  logic [TAG_BITS-1:0]       mem_req_tag,
    input  logic                      mem_req_data_valid,
    output logic                      mem_req_data_ready,
    input  logic [DATA_BITS-1:0]      mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0]    mem_req_data_mask,
    output logic                      mem_resp_valid,
    output logic [TAG_BITS-1:0]       mem_resp_tag,
    output logic [DATA_BITS-1:0]      mem_resp_data,
    output logic [$clog2(QDEPTH):0]   outstanding
);
    localparam int IDX_W  = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W  = $clog2(QDEPTH) + 1;
    localparam int AGE_W  = $clog2(LATENCY + 1);
    localparam int MASK_W = DATA_BITS / 8;
    // With LATENCY=1 a read answers at its own acceptance edge, so it never enters the queue.
    localparam bit BYPASS = (LATENCY == 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WDATA = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [DATA_BITS-1:0] ram [RAM_WORDS];

    logic [TAG_BITS-1:0]  r_q_tag  [QDEPTH];
    logic [DATA_BITS-1:0] r_q_data [QDEPTH];
    logic [AGE_W-1:0]     r_q_age  [QDEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [IDX_W-1:0]     r_waddr;

    logic                 r_req_ready;
    logic                 r_data_ready;
    logic                 r_resp_valid;
    logic [TAG_BITS-1:0]  r_resp_tag;
    logic [DATA_BITS-1:0] r_resp_data;

    logic [IDX_W-1:0]     w_req_idx;
    logic [DATA_BITS-1:0] w_rd_word;
    logic                 w_rd_fire;
    logic                 w_wr_fire;
    logic                 w_data_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_req_ready_nxt;
    logic                 w_data_ready_nxt;

    // Upper address bits simply alias onto the RAM.
    generate
        if (ADDR_BITS > IDX_W) begin : g_alias
            logic w_unused_hi;
            assign w_unused_hi = ^mem_req_addr[ADDR_BITS-1:IDX_W];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == QDEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_req_idx   = mem_req_addr[IDX_W-1:0];
    assign w_rd_word   = ram[w_req_idx];
    // r_req_ready is only ever high in IDLE and r_data_ready only in WDATA.
    assign w_rd_fire   = mem_req_valid && r_req_ready && !mem_req_rw;
    assign w_wr_fire   = mem_req_valid && r_req_ready && mem_req_rw;
    assign w_data_fire = mem_req_data_valid && r_data_ready;
    assign w_push      = w_rd_fire && !BYPASS;
    // The head leaves at the edge where its age becomes LATENCY-1, so the registered
    // response is visible LATENCY-1 edges after acceptance.
    assign w_pop       = (r_count != '0) &&
                         ((32'(r_q_age[r_rd_ptr]) + 32'd2) >= 32'(LATENCY));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_wr_fire)   w_state_nxt = S_WDATA;
            S_WDATA: if (w_data_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_count_nxt      = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_req_ready_nxt  = (w_state_nxt == S_IDLE) && (w_count_nxt < CNT_W'(QDEPTH));
        w_data_ready_nxt = (w_state_nxt == S_WDATA);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_waddr      <= '0;
            r_req_ready  <= 1'b0;
            r_data_ready <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
        end else begin
            r_count      <= w_count_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_data_ready <= w_data_ready_nxt;
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_wr_fire) r_waddr <= w_req_idx;

            r_resp_valid <= 1'b0;
            if (w_pop) begin
                r_resp_valid <= 1'b1;
                r_resp_tag   <= r_q_tag[r_rd_ptr];
                r_resp_data  <= r_q_data[r_rd_ptr];
            end else if (BYPASS && w_rd_fire) begin
                r_resp_valid <= 1'b1;
                r_resp_tag   <= mem_req_tag;
                r_resp_data  <= w_rd_word;
            end
        end
    end

    // Queue payload needs no reset: validity is carried entirely by the count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (r_q_age[i] < AGE_W'(LATENCY)) r_q_age[i] <= r_q_age[i] + AGE_W'(1);
        end
        if (w_push) begin
            r_q_tag[r_wr_ptr]  <= mem_req_tag;
            r_q_data[r_wr_ptr] <= w_rd_word;
            r_q_age[r_wr_ptr]  <= '0;
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (w_data_fire) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (mem_req_data_mask[b]) ram[r_waddr][8*b +: 8] <= mem_req_data_bits[8*b +: 8];
            end
        end
    end

    assign mem_req_ready      = r_req_ready;
    assign mem_req_data_ready = r_data_ready;
    assign mem_resp_valid     = r_resp_valid;
    assign mem_resp_tag       = r_resp_tag;
    assign mem_resp_data      = r_resp_data;
    assign outstanding        = r_count;

endmodule

// File: tb/tb_ext_mem_latency_model.sv
// tb/tb_ext_mem_latency_model.sv - directed vector bench for ext_mem_latency_model
module tb_ext_mem_latency_model;
    localparam int AB = 28;
    localparam int DB = 128;
    localparam int TB = 5;
    localparam int LAT_A = 4;
    localparam int LAT_B = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid_a = 1'b0;
    logic          req_valid_b = 1'b0;
    logic          req_rw = 1'b0;
    logic [AB-1:0] req_addr = '0;
    logic [TB-1:0] req_tag = '0;
    logic          data_valid = 1'b0;
    logic [DB-1:0] data_bits = '0;
    logic [15:0]   data_mask = '0;

    logic          req_ready_a, data_ready_a, resp_valid_a;
    logic [TB-1:0] resp_tag_a;
    logic [DB-1:0] resp_data_a;
    logic [2:0]    outstanding_a;
    logic          req_ready_b, data_ready_b, resp_valid_b;
    logic [TB-1:0] resp_tag_b;
    logic [DB-1:0] resp_data_b_unused;
    logic [2:0]    outstanding_b;

    always #5 clk = ~clk;

    ext_mem_latency_model #(.LATENCY(LAT_A), .QDEPTH(4)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .mem_req_valid(req_valid_a), .mem_req_ready(req_ready_a), .mem_req_rw(req_rw),
        .mem_req_addr(req_addr), .mem_req_tag(req_tag),
        .mem_req_data_valid(data_valid), .mem_req_data_ready(data_ready_a),
        .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
        .mem_resp_valid(resp_valid_a), .mem_resp_tag(resp_tag_a), .mem_resp_data(resp_data_a),
        .outstanding(outstanding_a)
    );

    ext_mem_latency_model #(.LATENCY(LAT_B), .QDEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .mem_req_valid(req_valid_b), .mem_req_ready(req_ready_b), .mem_req_rw(req_rw),
        .mem_req_addr(req_addr), .mem_req_tag(req_tag),
        .mem_req_data_valid(1'b0), .mem_req_data_ready(data_ready_b),
        .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
        .mem_resp_valid(resp_valid_b), .mem_resp_tag(resp_tag_b), .mem_resp_data(resp_data_b_unused),
        .outstanding(outstanding_b)
    );

    typedef struct {
        logic          rw;
        logic [AB-1:0] addr;
        logic [TB-1:0] tag;
        logic [DB-1:0] data;
        logic [15:0]   mask;
        logic [DB-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [DB-1:0] D_A5  = {16{8'hA5}};
    localparam logic [DB-1:0] D_FF  = {16{8'hFF}};
    localparam logic [DB-1:0] D_11  = {16{8'h11}};
    localparam logic [DB-1:0] D_M7  = 128'hffffffff_ffffffff_ffffffff_11111111;
    localparam logic [DB-1:0] D_AL  = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [DB-1:0] D_AL2 = 128'h00000000_89abcdef_fedcba98_76543210;

    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        int n;
        n = 0;
        while (!req_ready_a && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_wait", 128'(req_ready_a), 128'd1);
    endtask

    task automatic do_write(input logic [AB-1:0] addr, input logic [DB-1:0] data, input logic [15:0] mask);
        data_valid = 1'b1;
        data_bits  = data;
        data_mask  = mask;
        wait_ready_a();
        tick();
        check("early_beat_ready", 128'(data_ready_a), 128'd0);
        req_valid_a = 1'b1;
        req_rw      = 1'b1;
        req_addr    = addr;
        tick();
        req_valid_a = 1'b0;
        check("wdata_data_ready", 128'(data_ready_a), 128'd1);
        check("wdata_req_ready", 128'(req_ready_a), 128'd0);
        tick();
        data_valid = 1'b0;
        check("wdone_data_ready", 128'(data_ready_a), 128'd0);
        check("wdone_req_ready", 128'(req_ready_a), 128'd1);
    endtask

    task automatic do_read(input logic [AB-1:0] addr, input logic [TB-1:0] tag, input logic [DB-1:0] exp);
        int k;
        wait_ready_a();
        req_valid_a = 1'b1;
        req_rw      = 1'b0;
        req_addr    = addr;
        req_tag     = tag;
        tick();
        req_valid_a = 1'b0;
        k = 0;
        while (!resp_valid_a && k < 40) begin
            tick();
            k++;
        end
        check("rd_latency", 128'(k), 128'(LAT_A - 1));
        check("rd_tag", 128'(resp_tag_a), 128'(tag));
        check("rd_data", resp_data_a, exp);
        tick();
        check("rd_single_pulse", 128'(resp_valid_a), 128'd0);
    endtask

    int exp_acc[6] = '{0, 1, 2, 3, 8, 9};
    int acc_edge[6];
    int n_acc, n_resp, peak, pulses;
    logic rdy;

    initial begin
        vecs[0] = '{1'b1, 28'd5,    5'd0,  D_A5,          16'hFFFF, '0};
        vecs[1] = '{1'b0, 28'd5,    5'd3,  '0,            16'h0000, D_A5};
        vecs[2] = '{1'b1, 28'd7,    5'd0,  D_FF,          16'hFFFF, '0};
        vecs[3] = '{1'b1, 28'd7,    5'd0,  D_11,          16'h000F, '0};
        vecs[4] = '{1'b0, 28'd7,    5'd9,  '0,            16'h0000, D_M7};
        vecs[5] = '{1'b1, 28'd1026, 5'd0,  D_AL,          16'hFFFF, '0};
        vecs[6] = '{1'b0, 28'd2,    5'd17, '0,            16'h0000, D_AL};
        vecs[7] = '{1'b1, 28'd2,    5'd0,  '0,            16'hF000, '0};
        vecs[8] = '{1'b0, 28'd1026, 5'd31, '0,            16'h0000, D_AL2};
        vecs[9] = '{1'b0, 28'd5,    5'd0,  '0,            16'h0000, D_A5};

        // Reset values while held.
        repeat (3) tick();
        check("rst_req_ready", 128'(req_ready_a), 128'd0);
        check("rst_data_ready", 128'(data_ready_a), 128'd0);
        check("rst_resp_valid", 128'(resp_valid_a), 128'd0);
        check("rst_resp_tag", 128'(resp_tag_a), 128'd0);
        check("rst_resp_data", resp_data_a, 128'd0);
        check("rst_outstanding", 128'(outstanding_a), 128'd0);
        check("rst_req_ready_b", 128'(req_ready_b), 128'd0);
        reset_n = 1'b1;
        #1;
        check("deassert_ready_before_edge", 128'(req_ready_a), 128'd0);
        tick();
        check("ready_after_first_edge", 128'(req_ready_a), 128'd1);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].rw) do_write(vecs[v].addr, vecs[v].data, vecs[v].mask);
            else            do_read(vecs[v].addr, vecs[v].tag, vecs[v].exp);
        end

        // Streaming: 16 back-to-back reads, responses back-to-back LAT_A-1 edges later.
        for (int c = 0; c < 16 + LAT_A; c++) begin
            if (c < 16) begin
                req_valid_a = 1'b1;
                req_rw      = 1'b0;
                req_addr    = (c % 2 == 1) ? 28'd7 : 28'd5;
                req_tag     = TB'(c);
                check("stream_ready", 128'(req_ready_a), 128'd1);
            end else begin
                req_valid_a = 1'b0;
            end
            tick();
            if (c >= LAT_A - 1 && c - (LAT_A - 1) < 16) begin
                check("stream_valid", 128'(resp_valid_a), 128'd1);
                check("stream_tag", 128'(resp_tag_a), 128'(c - (LAT_A - 1)));
                check("stream_data", resp_data_a, ((c - (LAT_A - 1)) % 2 == 1) ? D_M7 : D_A5);
            end else begin
                check("stream_idle", 128'(resp_valid_a), 128'd0);
            end
        end
        req_valid_a = 1'b0;
        check("stream_drained", 128'(outstanding_a), 128'd0);

        // Full queue on the LATENCY=8, QDEPTH=4 instance: 6 reads offered continuously.
        n_acc = 0;
        n_resp = 0;
        peak = 0;
        for (int c = 0; c < 30; c++) begin
            rdy = req_ready_b;
            if (n_acc < 6) begin
                req_valid_b = 1'b1;
                req_rw      = 1'b0;
                req_addr    = AB'(n_acc);
                req_tag     = TB'(20 + n_acc);
            end else begin
                req_valid_b = 1'b0;
            end
            tick();
            if (rdy && n_acc < 6) begin
                acc_edge[n_acc] = c;
                n_acc++;
            end
            if (int'(outstanding_b) > peak) peak = int'(outstanding_b);
            if (resp_valid_b) begin
                if (n_resp < 6) begin
                    check("full_resp_tag", 128'(resp_tag_b), 128'(20 + n_resp));
                    check("full_resp_edge", 128'(c), 128'(exp_acc[n_resp] + LAT_B - 1));
                end
                n_resp++;
            end
        end
        req_valid_b = 1'b0;
        check("full_accepted", 128'(n_acc), 128'd6);
        check("full_responses", 128'(n_resp), 128'd6);
        check("full_peak", 128'(peak), 128'd4);
        for (int k = 0; k < 6; k++) begin
            if (k < n_acc) check("full_accept_edge", 128'(acc_edge[k]), 128'(exp_acc[k]));
        end

        // Reset with three reads in flight.
        for (int k = 0; k < 3; k++) begin
            req_valid_a = 1'b1;
            req_rw      = 1'b0;
            req_addr    = (k == 0) ? 28'd5 : ((k == 1) ? 28'd7 : 28'd2);
            req_tag     = TB'(k + 1);
            tick();
        end
        req_valid_a = 1'b0;
        check("flight_outstanding", 128'(outstanding_a), 128'd3);
        reset_n = 1'b0;
        #1;
        check("midrst_outstanding", 128'(outstanding_a), 128'd0);
        check("midrst_resp_valid", 128'(resp_valid_a), 128'd0);
        check("midrst_req_ready", 128'(req_ready_a), 128'd0);
        tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (resp_valid_a) pulses++;
        end
        check("midrst_stale_pulses", 128'(pulses), 128'd0);
        check("midrst_outstanding_after", 128'(outstanding_a), 128'd0);
        check("midrst_ready_after", 128'(req_ready_a), 128'd1);
        do_read(28'd5, 5'd6, D_A5);
        do_read(28'd7, 5'd7, D_M7);
        do_read(28'd2, 5'd8, D_AL2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
